scan_sel_gen: RTL and testbench
===============================

# scan_sel_gen

Multiplexed-display scan controller that sits directly upstream of the 3-to-8 active-low decoder. It generates the decoder's select code (A, B, C) and enables (G1, G2A, G3A), so that exactly one digit line is driven at a time, with a one-cycle dead gap between digits. It also holds a tear-free display register of eight 4-bit digit values. The value for the currently selected digit is presented on `seg_data`.

## Interface
- `DIV`, default 4: SHOW duration per digit in clock cycles; legal range 1..255.
- `NDIGITS`, default 8: number of digits scanned, codes 0..NDIGITS-1; legal range 1..8.

- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous assert and active-low.
- `en`, input, 1: run request.
- `wr_req`, input, 1: one-cycle write strobe for new display data.
- `wr_data`, input, 32: eight nibbles; digit k is bits [4k+3:4k].
- `wr_ack`, output, 1: one-cycle pulse when a pending word is committed to the display register.
- `A`, `B`, `C`, output, 1 each: select code; A is the LSB, C is the MSB.
- `G1`, output, 1: decoder enable, active-high.
- `G2A`, `G3A`, output, 1 each: decoder enables, active-low.
- `seg_data`, output, 4: display nibble for the current select code.
- `frame_start`, output, 1: one-cycle pulse at the start of each frame.

## Operation
- All outputs are registered.
- Reset values:
  - `A`, `B`, `C` = 0.
  - `G1` = 0, `G2A` = 1, `G3A` = 1 (decoder disabled, all Y_L high).
  - `seg_data` = 0, `wr_ack` = 0, `frame_start` = 0.
  - Display register = 0, pending register invalid, prescaler = 0, state = IDLE.
- Enable encoding: "enabled" means G1=1, G2A=0, G3A=0; "disabled" means G1=0, G2A=1, G3A=1. G2A and G3A always equal ~G1.
- State IDLE:
  - Decoder disabled; sel = 0.
  - If pending is valid: commit it to the display register, pulse `wr_ack`, clear pending.
  - If en=1: go to SHOW with sel=0 and prescaler=0.
- State SHOW:
  - Decoder enabled.
  - Prescaler counts 0..DIV-1; at DIV-1, go to GAP.
  - `frame_start`=1 on the first SHOW cycle of sel=0.
- State GAP:
  - Exactly one cycle, decoder disabled, sel held.
  - On exit, sel_next = (sel==NDIGITS-1) ? 0 : sel+1.
  - If sel_next==0 and pending is valid: commit to the display register in that cycle, pulse `wr_ack`, clear pending.
  - Then go to SHOW if en=1, otherwise go to IDLE (sel forced to 0).
- `en` is sampled only in IDLE and at GAP exit. Deasserting `en` in SHOW never truncates a digit.
- Writes:
  - `wr_req`=1 loads `wr_data` into pending and sets it valid in any state.
  - A second write before commit overwrites pending (latest wins); only one `wr_ack` is issued.
- Simultaneous write and commit: the commit uses the pre-write pending contents. The new word stays pending for the next frame boundary.
  - If pending was invalid, nothing commits and there is no ack.
  - In IDLE, a same-cycle write is committed on the following cycle.
- `seg_data` = display[4·sel+3 : 4·sel], updated whenever sel or the display register changes. It is registered in the same cycle as {C,B,A}.
- The display register only changes at a frame boundary or in IDLE. Displayed data therefore never tears mid-frame.
- Asynchronous reset mid-operation returns all state to the reset values immediately. Pending data is discarded.

## Timing
- Digit period = DIV+1 cycles: DIV cycles SHOW, then 1 cycle GAP.
- Frame period = NDIGITS·(DIV+1) cycles.
- en rises in IDLE at edge n → first SHOW cycle (G1=1, sel=0, `frame_start`=1) is visible after edge n+1.
- {C,B,A} changes only on the GAP→SHOW edge. It is stable for the whole SHOW window and for one cycle before it.
- `wr_ack` is asserted in the same cycle that the new display value becomes visible on `seg_data` (for sel=0).
- Write-to-display latency: at most one frame plus one cycle.
- NDIGITS=1: sel stays 0 and `frame_start` pulses every DIV+1 cycles.

## Test plan
- Reset, then en=1, DIV=4, NDIGITS=8:
  - G1 high for 4 cycles and low for 1 cycle, repeating.
  - {C,B,A} steps 0,1,…,7,0.
  - `frame_start` pulses every 40 cycles.
  - G2A and G3A always equal ~G1.
- en held 0: outputs stay at reset values. `wr_req` with 0x76543210 → `wr_ack` one cycle later. Then with en=1, `seg_data` reads 0,1,…,7 per digit.
- Running, write 0xFFFFFFFF mid-frame at sel=3:
  - `seg_data` keeps the old values for digits 4..7.
  - `wr_ack` and the new value 0xF appear together when sel wraps to 0.
- Two writes (0x11111111, then 0x22222222) within one frame → a single `wr_ack`, and 0x2 is displayed. A write coincident with the commit cycle defers to the next frame.
- en dropped in the second SHOW cycle of sel=5:
  - The SHOW completes its 4 cycles and the GAP runs.
  - Then IDLE with sel=0 and the decoder disabled.
  - en reasserted → the restart gives `frame_start` at sel=0.
- rst_n pulsed low in the middle of SHOW with a pending write:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - No `wr_ack` follows.
  - The display register reads 0 after restart.

Source files
------------

// File: rtl/scan_sel_gen.sv
// Scan controller for a 3-to-8 active-low decoder: one digit at a time with a dead gap,
// plus a tear-free eight-digit display register committed only at frame boundaries or in idle.
module scan_sel_gen #(
  parameter int DIV     = 4,
  parameter int NDIGITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        wr_req,
  input  logic [31:0] wr_data,
  output logic        wr_ack,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        G1,
  output logic        G2A,
  output logic        G3A,
  output logic [3:0]  seg_data,
  output logic        frame_start
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [2:0] LAST_SEL   = 3'(NDIGITS - 1);
  localparam logic [7:0] LAST_PRESC = 8'(DIV - 1);

  logic [1:0]  state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [7:0]  presc_q, presc_d;
  logic [31:0] disp_q, disp_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic        g1_q, g1_d;
  logic [3:0]  seg_q, seg_d;
  logic        wr_ack_q, wr_ack_d;
  logic        frame_start_q, frame_start_d;

  logic        commit;
  logic [2:0]  sel_next;
  logic [4:0]  nib_lsb;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d       = state_q;
    sel_d         = sel_q;
    presc_d       = presc_q;
    disp_d        = disp_q;
    pend_d        = pend_q;
    pend_vld_d    = pend_vld_q;
    wr_ack_d      = 1'b0;
    commit        = 1'b0;
    sel_next      = (sel_q == LAST_SEL) ? 3'd0 : sel_q + 3'd1;

    case (state_q)
      ST_IDLE: begin
        sel_d  = 3'd0;
        commit = pend_vld_q;
        if (en) begin
          state_d = ST_SHOW;
          presc_d = 8'd0;
        end
      end
      ST_SHOW: begin
        if (presc_q == LAST_PRESC) state_d = ST_GAP;
        else                       presc_d = presc_q + 8'd1;
      end
      ST_GAP: begin
        // A frame boundary is the only point where running data may be swapped.
        commit = (sel_next == 3'd0) && pend_vld_q;
        if (en) begin
          state_d = ST_SHOW;
          sel_d   = sel_next;
          presc_d = 8'd0;
        end else begin
          state_d = ST_IDLE;
          sel_d   = 3'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = 3'd0;
      end
    endcase

    if (commit) begin
      disp_d     = pend_q;
      wr_ack_d   = 1'b1;
      pend_vld_d = 1'b0;
    end
    // A write in the commit cycle survives as the next pending word.
    if (wr_req) begin
      pend_d     = wr_data;
      pend_vld_d = 1'b1;
    end

    g1_d          = (state_d == ST_SHOW);
    frame_start_d = (state_d == ST_SHOW) && (state_q != ST_SHOW) && (sel_d == 3'd0);
    nib_lsb       = {sel_d, 2'b00};
    seg_d         = disp_d[nib_lsb +: 4];
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sel_q         <= 3'd0;
      presc_q       <= 8'd0;
      disp_q        <= 32'd0;
      pend_q        <= 32'd0;
      pend_vld_q    <= 1'b0;
      g1_q          <= 1'b0;
      seg_q         <= 4'd0;
      wr_ack_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      presc_q       <= presc_d;
      disp_q        <= disp_d;
      pend_q        <= pend_d;
      pend_vld_q    <= pend_vld_d;
      g1_q          <= g1_d;
      seg_q         <= seg_d;
      wr_ack_q      <= wr_ack_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign A           = sel_q[0];
  assign B           = sel_q[1];
  assign C           = sel_q[2];
  assign G1          = g1_q;
  assign G2A         = ~g1_q;
  assign G3A         = ~g1_q;
  assign seg_data    = seg_q;
  assign wr_ack      = wr_ack_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Randomized and directed bench for scan_sel_gen: two instances (8 digits/DIV 4 and
// 1 digit/DIV 1) checked every cycle against a timeline-based reference model.
module tb_scan_sel_gen;

  localparam int DIV0 = 4, ND0 = 8;
  localparam int DIV1 = 1, ND1 = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        wr_req = 1'b0;
  logic [31:0] wr_data = 32'd0;

  logic       ack0, a0, b0, c0, g1_0, g2a0, g3a0, fs0;
  logic [3:0] seg0;
  logic       ack1, a1, b1, c1, g1_1, g2a1, g3a1, fs1;
  logic [3:0] seg1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  scan_sel_gen #(.DIV(DIV0), .NDIGITS(ND0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_req(wr_req), .wr_data(wr_data),
    .wr_ack(ack0), .A(a0), .B(b0), .C(c0), .G1(g1_0), .G2A(g2a0), .G3A(g3a0),
    .seg_data(seg0), .frame_start(fs0));

  scan_sel_gen #(.DIV(DIV1), .NDIGITS(ND1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_req(wr_req), .wr_data(wr_data),
    .wr_ack(ack1), .A(a1), .B(b1), .C(c1), .G1(g1_1), .G2A(g2a1), .G3A(g3a1),
    .seg_data(seg1), .frame_start(fs1));

  // Model: while running, t is the cycle number inside the current frame; digit and
  // show/gap phase follow from plain division by the digit period DIV+1.
  typedef struct packed {
    logic        running;
    logic [15:0] t;
    logic [31:0] disp;
    logic [31:0] pend;
    logic        pv;
    logic        ack;
  } mdl_t;

  mdl_t m0 = '0;
  mdl_t m1 = '0;

  function automatic mdl_t mdl_step(mdl_t m, int div, int nd, logic e, logic w, logic [31:0] d);
    mdl_t n = m;
    int per = div + 1;
    int t   = int'(m.t);
    n.ack = 1'b0;
    if (!m.running) begin
      if (m.pv) begin n.disp = m.pend; n.pv = 1'b0; n.ack = 1'b1; end
      if (e) begin n.running = 1'b1; n.t = 16'd0; end
    end else if (t % per == div) begin
      if (((t / per + 1) % nd == 0) && m.pv) begin
        n.disp = m.pend; n.pv = 1'b0; n.ack = 1'b1;
      end
      if (e) n.t = 16'((t + 1) % (nd * per));
      else   n.running = 1'b0;
    end else begin
      n.t = 16'(t + 1);
    end
    if (w) begin n.pend = d; n.pv = 1'b1; end
    return n;
  endfunction

  function automatic logic [2:0] m_sel(mdl_t m, int div, int nd);
    return m.running ? 3'((int'(m.t) / (div + 1)) % nd) : 3'd0;
  endfunction

  function automatic logic m_g1(mdl_t m, int div);
    return m.running && (int'(m.t) % (div + 1) < div);
  endfunction

  function automatic logic m_fs(mdl_t m, int div, int nd);
    return m.running && (int'(m.t) % (div + 1) == 0) && (m_sel(m, div, nd) == 3'd0);
  endfunction

  function automatic logic [3:0] m_seg(mdl_t m, int div, int nd);
    logic [31:0] dv = m.disp;
    return dv[4 * int'(m_sel(m, div, nd)) +: 4];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      m0 <= mdl_step(m0, DIV0, ND0, en, wr_req, wr_data);
      m1 <= mdl_step(m1, DIV1, ND1, en, wr_req, wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic e0, e1;
    e0 = m_g1(m0, DIV0);
    e1 = m_g1(m1, DIV1);
    check("d0.sel", {c0, b0, a0}, m_sel(m0, DIV0, ND0));
    check("d0.en",  {g1_0, g2a0, g3a0}, {e0, ~e0, ~e0});
    check("d0.seg", seg0, m_seg(m0, DIV0, ND0));
    check("d0.ack", ack0, m0.ack);
    check("d0.fs",  fs0, m_fs(m0, DIV0, ND0));
    check("d1.sel", {c1, b1, a1}, m_sel(m1, DIV1, ND1));
    check("d1.en",  {g1_1, g2a1, g3a1}, {e1, ~e1, ~e1});
    check("d1.seg", seg1, m_seg(m1, DIV1, ND1));
    check("d1.ack", ack1, m1.ack);
    check("d1.fs",  fs1, m_fs(m1, DIV1, ND1));
  endtask

  // One cycle: check what the last edge produced, then drive the next inputs.
  task automatic step(input logic e, input logic w, input logic [31:0] d);
    @(negedge clk);
    check_all();
    en      = e;
    wr_req  = w;
    wr_data = d;
  endtask

  function automatic logic at_pos(int s, int p);
    return m0.running && (int'(m_sel(m0, DIV0, ND0)) == s) && (int'(m0.t) % (DIV0 + 1) == p);
  endfunction

  // Keep running until digit s / phase p of dut0 is showing; bounded wait.
  task automatic run_until(input string tag, input int s, input int p);
    int i = 0;
    while (!at_pos(s, p) && i < 200) begin
      step(1'b1, 1'b0, 32'd0);
      i++;
    end
    check(tag, {31'd0, at_pos(s, p)}, 32'd1);
  endtask

  initial begin
    #1;
    check("rst.sel", {c0, b0, a0}, 32'd0);
    check("rst.en",  {g1_0, g2a0, g3a0}, 32'b011);
    check("rst.misc", {seg0, ack0, fs0}, 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with en=0, then a write commits from IDLE.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h7654_3210);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0);
    // Full frames showing 0..7.
    for (int i = 0; i < 90; i++) step(1'b1, 1'b0, 32'd0);

    // Mid-frame write at sel=3 waits for the wrap.
    run_until("reach_sel3", 3, 0);
    step(1'b1, 1'b1, 32'hFFFF_FFFF);
    for (int i = 0; i < 45; i++) step(1'b1, 1'b0, 32'd0);

    // Two writes in one frame: latest wins, single ack.
    run_until("reach_sel1", 1, 2);
    step(1'b1, 1'b1, 32'h1111_1111);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'h2222_2222);
    for (int i = 0; i < 45; i++) step(1'b1, 1'b0, 32'd0);

    // Write coincident with the commit cycle defers a frame.
    step(1'b1, 1'b1, 32'hAAAA_AAAA);
    run_until("reach_gap7", ND0 - 1, DIV0);
    step(1'b1, 1'b1, 32'hBBBB_BBBB);
    for (int i = 0; i < 85; i++) step(1'b1, 1'b0, 32'd0);

    // en dropped in the second SHOW cycle of sel=5.
    run_until("reach_sel5", 5, 1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 32'd0);

    // Random traffic.
    for (int i = 0; i < 700; i++)
      step($urandom_range(0, 15) != 0, $urandom_range(0, 11) == 0, $urandom);

    // Async reset mid-SHOW with a pending write.
    run_until("reach_sel2", 2, 1);
    step(1'b1, 1'b1, 32'hCCCC_CCCC);
    step(1'b1, 1'b0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst.sel", {c0, b0, a0}, 32'd0);
    check("arst.en",  {g1_0, g2a0, g3a0}, 32'b011);
    check("arst.misc", {seg0, ack0, fs0}, 32'd0);
    check("arst.d1en", {g1_1, g2a1, g3a1}, 32'b011);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) step(1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
